fp16_div: RTL and testbench
===========================

# fp16_div

Multi-cycle half-precision floating-point divider, q = a / b, computed as a × (1/b). It sits directly downstream of `fp16_recip` and instantiates it to produce the divisor reciprocal mantissa. It then multiplies by the dividend, normalises and packs the result. Valid/ready handshakes on both sides let it drop into streaming datapaths; it holds one operation in flight at a time.

## Interface
- No parameters; the format is fixed to IEEE-754 binary16.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous reset, active-low
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands
- `in_a`  in  16  dividend (fp16)
- `in_b`  in  16  divisor (fp16)
- `out_valid`  out  1  quotient valid
- `out_ready`  in  1  consumer accepts quotient
- `out_data`  out  16  quotient (fp16)

## Operation
- FSM states:
  - IDLE → RECIP → MUL → PACK → DONE, then back to IDLE.
  - Special-case path: IDLE → DONE.
- Acceptance:
  - `in_ready` = (state == IDLE).
  - An operand pair is accepted when `in_valid && in_ready`; in_a/in_b are captured into registers.
- Input classification, at accept:
  - Subnormal inputs are flushed to signed zero.
  - Sign of the result = sa ^ sb.
- Special cases (next state DONE, result registered immediately):
  - NaN in either operand, 0/0, or inf/inf → 16'h7C01.
  - x/0 or inf/finite → {s, 5'h1F, 10'h0}.
  - 0/finite or finite/inf → {s, 15'h0}.
- RECIP:
  - Drive `fp16_recip` with {1'b0, 5'd15, mb}, i.e. the divisor mantissa scaled into [1,2).
  - Register the result's exponent field er (14 or 15) and its 11-bit mantissa mr (hidden bit included).
- MUL:
  - prod[21:0] = {1,ma} × mr, registered.
  - e = ea − eb + er, held as a 7-bit signed value.
- PACK:
  - If prod[21]: e += 1 and mant = prod[20:11]; else mant = prod[19:10].
  - Rounding is truncation.
  - e ≥ 31 → inf; e ≤ 0 → signed zero (no subnormal outputs); otherwise {s, e[4:0], mant].
  - Register the result into `out_data`.
- DONE:
  - `out_valid` = 1; `out_data` is held stable until `out_ready`.
  - On `out_valid && out_ready` the next state is IDLE. There is no same-cycle re-accept.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, `out_valid` = 0, `out_data` = 16'h0000, so `in_ready` = 1 once rst_n is high.
  - Reset mid-operation aborts the operation and the quotient is discarded.
- Normal latency: accept at edge N, then RECIP at N+1, MUL at N+2, PACK at N+3; `out_valid` rises after edge N+4, in the same cycle as DONE.
- Special-case latency: `out_valid` rises after edge N+1.
- Throughput: at most one operation per (latency + 1) cycles. `in_ready` stays low from accept until the cycle after the output handshake.
- Backpressure: `out_valid`/`out_data` must not change while `out_ready` is low.
- Combinational depth: `fp16_recip` and the 11×11 multiplier are each isolated between register stages.

## Structure
- Shared package `fp16_pkg`:
  - FP16_QNAN = 16'h7C01, FP16_BIAS = 15, FP16_EXP_MAX = 31.
  - FP16_POS_INF and FP16_NEG_INF.
  - Divider state encoding.
  - Special-value classification functions (is_nan, is_inf, is_zero), reused by `fp16_recip` users.
- Sub-module: one instance of the existing `fp16_recip`. The multiplier and packer are inline.
- Expected size: about 200 lines of RTL.

## Test plan
- 6.0 / 2.0: in_a = 0x4600, in_b = 0x4000 → out_data = 0x4200; `out_valid` asserts in the cycle after edge N+4.
- −4.0 / 2.0: 0xC400 / 0x4000 → 0xC000. Then 1.0 / 3.0: 0x3C00 / 0x4200 → 0x3555 ±1 ulp.
- Specials, each with latency 1:
  - 0x0000 / 0x0000 → 0x7C01.
  - 0x3C00 / 0x8000 → 0xFC00.
  - 0x7E00 / 0x3C00 → 0x7C01.
  - 0x3C00 / 0x7C00 → 0x0000.
- Range limits:
  - 0x7BFF / 0x0400 → 0x7C00 (overflow).
  - 0x0400 / 0x7800 → 0x0000 (underflow).
  - 0x0200 / 0x3C00 → 0x0000 (subnormal flush).
- Backpressure: hold `out_ready` low for 5 cycles after `out_valid`. `out_data` stays stable, `in_ready` stays 0, and a pending `in_valid` is not accepted until the cycle after the handshake.
- Reset during MUL: pull rst_n low for one edge. `out_valid` stays 0, `in_ready` = 1 next cycle, and a following 6.0/2.0 produces 0x4200.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared binary16 constants, divider state encoding and special-value classifiers.
package fp16_pkg;

  localparam logic [15:0] FP16_QNAN    = 16'h7C01;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam int unsigned FP16_BIAS    = 15;
  localparam int unsigned FP16_EXP_MAX = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECIP,
    ST_MUL,
    ST_PACK,
    ST_DONE
  } div_state_e;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == '0);
  endfunction

  // Subnormals are flushed, so a zero exponent field means zero.
  function automatic logic is_zero(input logic [15:0] x);
    return x[14:10] == '0;
  endfunction

endpackage

// File: rtl/fp16_recip.sv
// Combinational binary16 reciprocal with truncated mantissa; subnormal results flush to zero.
module fp16_recip
  import fp16_pkg::*;
(
  input  logic [15:0] operand,
  output logic [15:0] result
);

  logic [10:0] sig;
  logic [10:0] quot;
  logic [6:0]  exp_r;

  always_comb begin
    sig   = {1'b1, operand[9:0]};
    quot  = 11'(22'h200000 / {11'd0, sig});
    // 1.0 keeps its exponent; any other significand gives 1/m in (0.5,1) and drops one
    exp_r = 7'd30 - {2'b00, operand[14:10]} - {6'd0, |operand[9:0]};
    result = {operand[15], exp_r[4:0], quot[9:0]};
    if (is_nan(operand))
      result = FP16_QNAN;
    else if (is_inf(operand))
      result = {operand[15], 15'h0};
    else if (is_zero(operand))
      result = {operand[15], 5'h1F, 10'h0};
    else if (exp_r[6] || (exp_r == '0))
      result = {operand[15], 15'h0};
  end

endmodule

// File: rtl/fp16_div.sv
// Multi-cycle binary16 divider q = a * (1/b), one operation in flight, valid/ready on both sides.
module fp16_div
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  div_state_e state, state_next;

  logic [4:0]        a_exp_q, b_exp_q, er_q;
  logic [9:0]        a_man_q, b_man_q;
  logic [10:0]       mr_q;
  logic [11:0]       prod_q;
  logic signed [6:0] e_q;
  logic              sign_q;

  logic              sign_in;
  logic              special_hit;
  logic [15:0]       special_val;
  logic [15:0]       recip_out;
  logic signed [6:0] e_adj;
  logic [9:0]        mant;
  logic [15:0]       pack_val;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  fp16_recip u_recip (
    .operand (16'({1'b0, 5'(FP16_BIAS), b_man_q})),
    .result  (recip_out)
  );

  always_comb begin
    sign_in     = in_a[15] ^ in_b[15];
    special_hit = 1'b1;
    special_val = FP16_QNAN;
    if (is_nan(in_a) || is_nan(in_b) || (is_zero(in_a) && is_zero(in_b)) ||
        (is_inf(in_a) && is_inf(in_b)))
      special_val = FP16_QNAN;
    else if (is_zero(in_b) || is_inf(in_a))
      special_val = {sign_in, 5'h1F, 10'h0};
    else if (is_zero(in_a) || is_inf(in_b))
      special_val = {sign_in, 15'h0};
    else
      special_hit = 1'b0;
  end

  // prod_q holds product bits [21:10]; bit 11 is the overflow-into-[2,4) flag.
  always_comb begin
    e_adj = e_q + 7'(prod_q[11]);
    mant  = prod_q[11] ? prod_q[10:1] : prod_q[9:0];
    if (e_adj >= 7'sd31)
      pack_val = {sign_q, 5'h1F, 10'h0};
    else if (e_adj <= 7'sd0)
      pack_val = {sign_q, 15'h0};
    else
      pack_val = {sign_q, e_adj[4:0], mant};
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (in_valid) state_next = special_hit ? ST_DONE : ST_RECIP;
      ST_RECIP: state_next = ST_MUL;
      ST_MUL:   state_next = ST_PACK;
      ST_PACK:  state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_exp_q  <= '0;
      a_man_q  <= '0;
      b_exp_q  <= '0;
      b_man_q  <= '0;
      sign_q   <= 1'b0;
      er_q     <= '0;
      mr_q     <= '0;
      prod_q   <= '0;
      e_q      <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (in_valid) begin
          a_exp_q <= in_a[14:10];
          a_man_q <= in_a[9:0];
          b_exp_q <= in_b[14:10];
          b_man_q <= in_b[9:0];
          sign_q  <= sign_in;
          if (special_hit) out_data <= special_val;
        end
        ST_RECIP: begin
          er_q   <= recip_out[14:10];
          mr_q   <= {1'b1, recip_out[9:0]};
          // the reciprocal is fed a positive operand, so this leaves the sign unchanged
          sign_q <= sign_q ^ recip_out[15];
        end
        ST_MUL: begin
          prod_q <= 12'((22'({1'b1, a_man_q}) * 22'(mr_q)) >> 10);
          e_q    <= $signed({2'b00, a_exp_q}) - $signed({2'b00, b_exp_q}) +
                    $signed({2'b00, er_q});
        end
        ST_PACK: out_data <= pack_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div.sv
// Randomised and directed bench for fp16_div against an integer-arithmetic quotient model.
module tb_fp16_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks = 0;
  int passes = 0;

  fp16_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Quotient from the algorithm's rules: a times truncated 1/b, product truncated, no subnormals.
  function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b,
                                          output bit spec);
    int     ea, eb, e, off;
    longint ma, mb, sa, sr, p;
    bit     s, za, zb, ia, ib, na, nb;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = longint'(a[9:0]);
    mb = longint'(b[9:0]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 31) && (ma == 0);
    ib = (eb == 31) && (mb == 0);
    na = (ea == 31) && (ma != 0);
    nb = (eb == 31) && (mb != 0);
    spec = 1'b1;
    if (na || nb || (za && zb) || (ia && ib)) return 16'h7C01;
    if (zb || ia) return {s, 5'h1F, 10'h000};
    if (za || ib) return {s, 15'h0000};
    spec = 1'b0;
    sa = 1024 + ma;
    if (mb == 0) begin
      sr  = 1024;
      off = 0;
    end else begin
      sr  = (2048 * 1024) / (1024 + mb);
      off = -1;
    end
    p = sa * sr;
    e = ea - eb + off + 15;
    while (p >= 2 * 1048576) begin
      p = p / 2;
      e = e + 1;
    end
    if (e >= 31) return {s, 5'h1F, 10'h000};
    if (e <= 0) return {s, 15'h0000};
    return {s, 5'(e), 10'(p / 1024 - 1024)};
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting posedge.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int waited;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    check_eq("accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts posedges from the accepting one up to out_valid.
  task automatic recv(output logic [15:0] q, output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_eq("out_valid_seen", 32'(out_valid), 32'd1);
    q = out_data;
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] want, input int want_lat);
    logic [15:0] q;
    int          lat;
    send(a, b);
    recv(q, lat);
    check_eq({tag, "_data"}, 32'(q), 32'(want));
    check_eq({tag, "_lat"}, 32'(lat), 32'(want_lat));
    @(negedge clk);
    check_eq({tag, "_ready_after"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  logic [15:0] dir_a [10] = '{16'h4600, 16'hC400, 16'h3C00, 16'h0000, 16'h3C00,
                              16'h7E00, 16'h3C00, 16'h7BFF, 16'h0400, 16'h0200};
  logic [15:0] dir_b [10] = '{16'h4000, 16'h4000, 16'h4200, 16'h0000, 16'h8000,
                              16'h3C00, 16'h7C00, 16'h0400, 16'h7800, 16'h3C00};
  logic [15:0] dir_q [10] = '{16'h4200, 16'hC000, 16'h3555, 16'h7C01, 16'hFC00,
                              16'h7C01, 16'h0000, 16'h7C00, 16'h0000, 16'h0000};
  int          dir_l [10] = '{4, 4, 4, 1, 1, 1, 1, 4, 4, 1};

  initial begin
    logic [15:0] a, b, want, q;
    bit          spec;
    int          lat;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++)
      op($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_q[i], dir_l[i]);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end else begin
        a = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
        b = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
      end
      want = ref_div(a, b, spec);
      op($sformatf("rnd%0d_%h_%h", i, a, b), a, b, want, spec ? 1 : 4);
    end

    // Backpressure with a second operand pair waiting on the input side.
    out_ready = 1'b0;
    want = ref_div(16'h3C00, 16'h4200, spec);
    send(16'h3C00, 16'h4200);
    recv(q, lat);
    check_eq("bp_data", 32'(q), 32'(want));
    in_a = 16'hC400;
    in_b = 16'h4000;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("bp_hold%0d", k), {14'd0, out_valid, in_ready, out_data},
               {14'd0, 1'b1, 1'b0, want});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_after_handshake", {30'd0, in_ready, out_valid}, 32'b10);
    op("bp_pending", 16'hC400, 16'h4000, 16'hC000, 4);

    // Reset while the operation sits in MUL.
    send(16'h4600, 16'h4000);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_mid_ready", {30'd0, in_ready, out_valid}, 32'b10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_mid_quiet%0d", k), 32'(out_valid), 32'd0);
    end
    op("after_rst", 16'h4600, 16'h4000, 16'h4200, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
